// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM state codes, handshake levels and datapath widths.
package div_pkg;

  localparam int DATA_W  = 32;
  localparam int DWORD_W = 64;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per clock, result as {remainder, quotient}.
// Optional cancel via annul_i when DIV_ANNUL_EN is defined.
module div
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [DWORD_W-1:0]  result_o,
  output logic                ready_o,
  output logic                busy_o
);

  logic [1:0]          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  // Partial remainder lives in [64:33]; dividend bits shift out of [32:1] as quotient bits enter at [0].
  logic [DWORD_W:0]    work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                sign1_q, sign1_d, sign2_q, sign2_d, signed_q, signed_d;
  logic [DWORD_W-1:0]  result_q, result_d;
  logic                ready_q, ready_d;

  logic                annul;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   mag1, mag2, quot_fix, rem_fix;

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  logic unused_annul;
  assign unused_annul = annul_i;
  assign annul        = 1'b0;
`endif

  assign mag1  = (signed_div_i && opdata1_i[DATA_W-1]) ? (32'd0 - opdata1_i) : opdata1_i;
  assign mag2  = (signed_div_i && opdata2_i[DATA_W-1]) ? (32'd0 - opdata2_i) : opdata2_i;
  assign trial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

  assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (32'd0 - work_q[31:0]) : work_q[31:0];
  assign rem_fix  = (signed_q && sign1_q) ? (32'd0 - work_q[64:33]) : work_q[64:33];

  // NOTE: every next-state signal takes its current value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul) begin
          sign1_d   = opdata1_i[DATA_W-1];
          sign2_d   = opdata2_i[DATA_W-1];
          signed_d  = signed_div_i;
          divisor_d = mag2;
          work_d    = {32'd0, mag1, 1'b0};
          cnt_d     = 6'd0;
          state_d   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        // Dwells two cycles so a zero divisor answers on the second edge after accept.
        if (annul) begin
          state_d = DIV_FREE;
        end else if (cnt_q == 6'd0) begin
          cnt_d = 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul) begin
          state_d = DIV_FREE;
        end else if (cnt_q != 6'd32) begin
          work_d = trial[DATA_W] ? {work_q[63:0], 1'b0} : {trial[31:0], work_q[31:0], 1'b1};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: latency, signed/unsigned results, divide-by-zero, hold, annul, reset.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Accept a request, scramble the operands afterwards, then wait (bounded) for ready_o.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    opdata1_i    = ~a;
    opdata2_i    = b + 32'd3;
    signed_div_i = ~sgn;
    lat = 0;
    while (!ready_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
  endtask

  task automatic release_req(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rdy_clr"}, 64'(ready_o), 64'd0);
    check({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    #12;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    release_req("u100_7");
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    release_req("s_m7_2");
    run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
    release_req("u_m7_2");
    run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    release_req("s_m100_7");
    run_div("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
    release_req("s_100_m7");
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
    release_req("u5_0");
    run_div("s5_0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
    release_req("s5_0");

    // Overflow case wraps; start_i held in END must neither restart nor disturb the result.
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", result_o, {32'd0, 32'h8000_0000});
      check("hold_rdy", 64'(ready_o), 64'd1);
      check("hold_busy", 64'(busy_o), 64'd0);
    end
    release_req("s_ovf");

    // annul_i pulsed while cnt == 10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
`ifdef DIV_ANNUL_EN
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
`else
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ign_busy", 64'(busy_o), 64'd1);
    lat = 11;
    while (!ready_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("annul_ign_lat", 64'(lat), 64'd33);
    check("annul_ign_res", result_o, {32'd2, 32'd14});
    release_req("annul_ign");
`endif

    // Asynchronous reset at cnt == 20, then a fresh request.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_result", result_o, 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("after_rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
    release_req("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
